// File: rtl/fde_pkg.sv
// Shared types and decoder for the fde_unit RV32I front end.
// FDE_RV32M_EN enables decoding of MUL/MULH/MULHSU/MULHU.
package fde_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH1, ST_FETCH2, ST_READ, ST_EXEC, ST_DONE
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
        ALU_SRA, ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU
    } alu_op_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [31:0] imm;
        alu_op_t     alu_op;
        logic        is_lui;
        logic        is_auipc;
        logic        is_jal;
        logic        is_jalr;
        logic        is_branch;
        logic        is_load;
        logic        is_store;
        logic        is_alu_imm;
        logic        is_alu_reg;
        logic        writes_rd;
        logic        illegal;
    } instructions;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
    } regvpair;

    function automatic alu_op_t alu_sel(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic instructions decode(input logic [31:0] i);
        instructions d;
        logic [6:0]  opc;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic        uses_rs1;
        logic        uses_rs2;
        logic        has_rd;
        opc = i[6:0];
        f3  = i[14:12];
        f7  = i[31:25];
        d = '0;
        d.rd     = i[11:7];
        d.rs1    = i[19:15];
        d.rs2    = i[24:20];
        d.funct3 = f3;
        d.alu_op = ALU_ADD;
        case (opc)
            OPC_LUI: begin
                d.is_lui = 1'b1;
                d.imm    = {i[31:12], 12'd0};
            end
            OPC_AUIPC: begin
                d.is_auipc = 1'b1;
                d.imm      = {i[31:12], 12'd0};
            end
            OPC_JAL: begin
                d.is_jal = 1'b1;
                d.imm    = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            end
            OPC_JALR: begin
                d.is_jalr = 1'b1;
                d.illegal = (f3 != 3'b000);
                d.imm     = {{20{i[31]}}, i[31:20]};
            end
            OPC_BRANCH: begin
                d.is_branch = 1'b1;
                d.illegal   = (f3 == 3'b010) || (f3 == 3'b011);
                d.imm       = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            end
            OPC_LOAD: begin
                d.is_load = 1'b1;
                d.illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
                d.imm     = {{20{i[31]}}, i[31:20]};
            end
            OPC_STORE: begin
                d.is_store = 1'b1;
                d.illegal  = (f3 > 3'b010);
                d.imm      = {{20{i[31]}}, i[31:25], i[11:7]};
            end
            OPC_OPIMM: begin
                d.is_alu_imm = 1'b1;
                d.imm        = {{20{i[31]}}, i[31:20]};
                d.alu_op     = alu_sel(f3, (f3 == F3_SR) && i[30]);
                if (f3 == F3_SLL)
                    d.illegal = (f7 != F7_BASE);
                else if (f3 == F3_SR)
                    d.illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
            end
            OPC_OP: begin
                d.is_alu_reg = 1'b1;
                if (f7 == F7_BASE)
                    d.alu_op = alu_sel(f3, 1'b0);
                else if ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)))
                    d.alu_op = alu_sel(f3, 1'b1);
`ifdef FDE_RV32M_EN
                else if ((f7 == F7_MULDIV) && !f3[2]) begin
                    case (f3[1:0])
                        2'b00:   d.alu_op = ALU_MUL;
                        2'b01:   d.alu_op = ALU_MULH;
                        2'b10:   d.alu_op = ALU_MULHSU;
                        default: d.alu_op = ALU_MULHU;
                    endcase
                end
`endif
                else
                    d.illegal = 1'b1;
            end
            OPC_FENCE: begin
            end
            default: d.illegal = 1'b1;
        endcase

        // An illegal encoding must look like a bubble downstream.
        if (d.illegal) begin
            d = '0;
            d.illegal = 1'b1;
        end
        uses_rs1 = d.is_jalr | d.is_branch | d.is_load | d.is_store | d.is_alu_imm | d.is_alu_reg;
        uses_rs2 = d.is_branch | d.is_store | d.is_alu_reg;
        has_rd   = d.is_lui | d.is_auipc | d.is_jal | d.is_jalr | d.is_load
                 | d.is_alu_imm | d.is_alu_reg;
        if (!uses_rs1) d.rs1 = 5'd0;
        if (!uses_rs2) d.rs2 = 5'd0;
        if (!has_rd)   d.rd  = 5'd0;
        if (d.is_lui | d.is_auipc | d.is_jal) d.funct3 = 3'd0;
        d.writes_rd = has_rd && (d.rd != 5'd0);
        return d;
    endfunction

endpackage

// File: rtl/fde_alu.sv
// Combinational ALU and branch comparator for fde_unit.
// Multiply operations exist only when FDE_RV32M_EN is defined.
module fde_alu
    import fde_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_y,
    output logic        o_br_taken
);

    logic signed [31:0] w_a_s;
    logic signed [31:0] w_b_s;
    logic        [4:0]  w_sh;

    assign w_a_s = i_a;
    assign w_b_s = i_b;
    assign w_sh  = i_b[4:0];

`ifdef FDE_RV32M_EN
    // Sign/zero-extend to 64 bits; the low 64 bits of the product are exact.
    logic [63:0] w_prod_ss;
    logic [63:0] w_prod_su;
    logic [63:0] w_prod_uu;
    assign w_prod_ss = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_prod_su = {{32{i_a[31]}}, i_a} * {32'd0, i_b};
    assign w_prod_uu = {32'd0, i_a} * {32'd0, i_b};
`endif

    always_comb begin
        o_y = 32'd0;
        case (alu_op_t'(i_op))
            ALU_ADD:  o_y = i_a + i_b;
            ALU_SUB:  o_y = i_a - i_b;
            ALU_SLL:  o_y = i_a << w_sh;
            ALU_SLT:  o_y = {31'd0, (w_a_s < w_b_s)};
            ALU_SLTU: o_y = {31'd0, (i_a < i_b)};
            ALU_XOR:  o_y = i_a ^ i_b;
            ALU_SRL:  o_y = i_a >> w_sh;
            ALU_SRA:  o_y = w_a_s >>> w_sh;
            ALU_OR:   o_y = i_a | i_b;
            ALU_AND:  o_y = i_a & i_b;
`ifdef FDE_RV32M_EN
            ALU_MUL:    o_y = w_prod_uu[31:0];
            ALU_MULH:   o_y = w_prod_ss[63:32];
            ALU_MULHSU: o_y = w_prod_su[63:32];
            ALU_MULHU:  o_y = w_prod_uu[63:32];
`endif
            default:  o_y = 32'd0;
        endcase
    end

    always_comb begin
        o_br_taken = 1'b0;
        case (i_funct3)
            F3_BEQ:  o_br_taken = (i_a == i_b);
            F3_BNE:  o_br_taken = (i_a != i_b);
            F3_BLT:  o_br_taken = (w_a_s < w_b_s);
            F3_BGE:  o_br_taken = (w_a_s >= w_b_s);
            F3_BLTU: o_br_taken = (i_a < i_b);
            F3_BGEU: o_br_taken = (i_a >= i_b);
            default: o_br_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/fde_unit.sv
// Multi-cycle RV32I fetch/decode/execute front end (IDLE-FETCH1-FETCH2-READ-EXEC-DONE).
// Define FDE_RV32M_EN to add MUL/MULH/MULHSU/MULHU.
module fde_unit
    import fde_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        enabled,
    input  logic [31:0] pc,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic [4:0]  rs1_a,
    output logic [4:0]  rs2_a,
    input  logic [31:0] rs1_v,
    input  logic [31:0] rs2_v,
    output logic        completed,
    output logic [31:0] pc_n,
    output logic [4:0]  rd,
    output logic        writes_to_reg,
    output logic        is_load,
    output logic        is_store,
    output logic [2:0]  funct3,
    output logic [31:0] store_data,
    output logic [31:0] result,
    output logic        is_jump_chosen,
    output logic [31:0] jump_dest,
    output logic        illegal
);

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    instructions r_dec;
    instructions w_dec_rom;
    regvpair     w_regs;
    alu_op_t     w_op;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] w_alu_y;
    logic        w_br_taken;
    logic        w_has_result;
    logic [31:0] w_jalr_sum;
    logic [31:0] w_dest;
    logic        w_taken;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (enabled) begin
                    w_next   = ST_FETCH1;
                    w_accept = 1'b1;
                end
            end
            ST_FETCH1: w_next = ST_FETCH2;
            ST_FETCH2: w_next = ST_READ;
            ST_READ:   w_next = ST_EXEC;
            ST_EXEC:   w_next = ST_DONE;
            default:   w_next = ST_IDLE;
        endcase
    end

    assign w_dec_rom = decode(rom_data);

    // Register-file addresses come straight from the decoded instruction so
    // they are stable from READ onwards and the data is ready by EXEC.
    assign rs1_a = r_dec.rs1;
    assign rs2_a = r_dec.rs2;

    assign w_regs.rs1 = rs1_v;
    assign w_regs.rs2 = rs2_v;

    always_comb begin
        w_op = r_dec.alu_op;
        w_a  = w_regs.rs1;
        w_b  = w_regs.rs2;
        if (r_dec.is_lui) begin
            w_op = ALU_ADD;
            w_a  = 32'd0;
            w_b  = r_dec.imm;
        end else if (r_dec.is_auipc) begin
            w_op = ALU_ADD;
            w_a  = rom_addr;
            w_b  = r_dec.imm;
        end else if (r_dec.is_jal || r_dec.is_jalr) begin
            w_op = ALU_ADD;
            w_a  = rom_addr;
            w_b  = 32'd4;
        end else if (r_dec.is_load || r_dec.is_store) begin
            w_op = ALU_ADD;
            w_b  = r_dec.imm;
        end else if (r_dec.is_alu_imm) begin
            w_b  = r_dec.imm;
        end
    end

    fde_alu u_alu (
        .i_op       (w_op),
        .i_funct3   (r_dec.funct3),
        .i_a        (w_a),
        .i_b        (w_b),
        .o_y        (w_alu_y),
        .o_br_taken (w_br_taken)
    );

    assign w_has_result = r_dec.is_lui | r_dec.is_auipc | r_dec.is_jal | r_dec.is_jalr
                        | r_dec.is_load | r_dec.is_store | r_dec.is_alu_imm | r_dec.is_alu_reg;
    assign w_jalr_sum   = w_regs.rs1 + r_dec.imm;
    assign w_taken      = r_dec.is_jal | r_dec.is_jalr | (r_dec.is_branch & w_br_taken);

    always_comb begin
        w_dest = 32'd0;
        if (r_dec.is_jalr)
            w_dest = w_jalr_sum & ~32'd1;
        else if (r_dec.is_jal || r_dec.is_branch)
            w_dest = rom_addr + r_dec.imm;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rom_addr       <= 32'd0;
            r_dec          <= '0;
            completed      <= 1'b0;
            pc_n           <= 32'd0;
            rd             <= 5'd0;
            writes_to_reg  <= 1'b0;
            is_load        <= 1'b0;
            is_store       <= 1'b0;
            funct3         <= 3'd0;
            store_data     <= 32'd0;
            result         <= 32'd0;
            is_jump_chosen <= 1'b0;
            jump_dest      <= 32'd0;
            illegal        <= 1'b0;
        end else begin
            if (w_accept) begin
                rom_addr  <= pc;
                completed <= 1'b0;
            end
            if (r_state == ST_FETCH2)
                r_dec <= w_dec_rom;
            if (r_state == ST_EXEC) begin
                completed      <= 1'b1;
                pc_n           <= rom_addr;
                rd             <= r_dec.rd;
                writes_to_reg  <= r_dec.writes_rd;
                is_load        <= r_dec.is_load;
                is_store       <= r_dec.is_store;
                funct3         <= r_dec.funct3;
                store_data     <= w_regs.rs2;
                result         <= w_has_result ? w_alu_y : 32'd0;
                is_jump_chosen <= w_taken;
                jump_dest      <= w_dest;
                illegal        <= r_dec.illegal;
            end
        end
    end

endmodule

// File: tb/tb_fde_unit.sv
// Scoreboard bench for fde_unit: directed instructions, queued expectations, decoupled monitor.
module tb_fde_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enabled = 1'b0;
    logic [31:0] pc = 32'd0;
    logic [31:0] rom_addr;
    logic [31:0] rom_data = 32'd0;
    logic [4:0]  rs1_a;
    logic [4:0]  rs2_a;
    logic [31:0] rs1_v = 32'd0;
    logic [31:0] rs2_v = 32'd0;
    logic        completed;
    logic [31:0] pc_n;
    logic [4:0]  rd;
    logic        writes_to_reg;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] store_data;
    logic [31:0] result;
    logic        is_jump_chosen;
    logic [31:0] jump_dest;
    logic        illegal;

    fde_unit dut (
        .clk            (clk),
        .rstn           (rstn),
        .enabled        (enabled),
        .pc             (pc),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .rs1_a          (rs1_a),
        .rs2_a          (rs2_a),
        .rs1_v          (rs1_v),
        .rs2_v          (rs2_v),
        .completed      (completed),
        .pc_n           (pc_n),
        .rd             (rd),
        .writes_to_reg  (writes_to_reg),
        .is_load        (is_load),
        .is_store       (is_store),
        .funct3         (funct3),
        .store_data     (store_data),
        .result         (result),
        .is_jump_chosen (is_jump_chosen),
        .jump_dest      (jump_dest),
        .illegal        (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] t;
        logic [31:0] pc_n;
        logic [4:0]  rd;
        logic        wr;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] sd;
        logic [31:0] res;
        logic        jmp;
        logic [31:0] dest;
        logic        ill;
        logic [4:0]  rs1a;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] cyc = 32'd0;
    logic [31:0] rom_pc = 32'hFFFF_FFF0;
    logic [31:0] rom_word = 32'd0;
    logic [31:0] regs [32];

    always @(posedge clk) cyc <= cyc + 32'd1;

    // One-cycle ROM: only the address under test returns the instruction.
    always @(posedge clk) rom_data <= (rom_addr == rom_pc) ? rom_word : 32'd0;

    always @(posedge clk) begin
        rs1_v <= (rs1_a == 5'd0) ? 32'd0 : regs[rs1_a];
        rs2_v <= (rs2_a == 5'd0) ? 32'd0 : regs[rs2_a];
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    function automatic exp_t mk(input logic [4:0] r, input logic w, input logic l, input logic s,
                                input logic [2:0] f, input logic [31:0] sdv, input logic [31:0] res,
                                input logic j, input logic [31:0] d, input logic il, input logic [4:0] a1);
        exp_t e;
        e = '0;
        e.rd = r; e.wr = w; e.ld = l; e.st = s; e.f3 = f; e.sd = sdv;
        e.res = res; e.jmp = j; e.dest = d; e.ill = il; e.rs1a = a1;
        return e;
    endfunction

    // Monitor: new result on each rising completed; outputs must then hold.
    logic prev_c = 1'b0;
    exp_t cur;
    logic have = 1'b0;
    always @(negedge clk) begin
        if (rstn && completed && !prev_c) begin
            if (q.size() == 0) begin
                chk("unexpected_completed", 32'd1, 32'd0);
            end else begin
                cur = q.pop_front();
                have = 1'b1;
                chk("latency", cyc - cur.t, 32'd4);
                chk("pc_n", pc_n, cur.pc_n);
                chk("rd", {27'd0, rd}, {27'd0, cur.rd});
                chk("writes_to_reg", {31'd0, writes_to_reg}, {31'd0, cur.wr});
                chk("is_load", {31'd0, is_load}, {31'd0, cur.ld});
                chk("is_store", {31'd0, is_store}, {31'd0, cur.st});
                chk("funct3", {29'd0, funct3}, {29'd0, cur.f3});
                chk("store_data", store_data, cur.sd);
                chk("result", result, cur.res);
                chk("is_jump_chosen", {31'd0, is_jump_chosen}, {31'd0, cur.jmp});
                chk("jump_dest", jump_dest, cur.dest);
                chk("illegal", {31'd0, illegal}, {31'd0, cur.ill});
                chk("rs1_a", {27'd0, rs1_a}, {27'd0, cur.rs1a});
            end
        end else if (rstn && completed && have) begin
            chk("hold_result", result, cur.res);
            chk("hold_dest", jump_dest, cur.dest);
        end
        prev_c = completed;
    end

    task automatic issue(input logic [31:0] p, input logic [31:0] instr, input exp_t e_in, input bit poke);
        exp_t e;
        e = e_in;
        rom_pc   = p;
        rom_word = instr;
        pc       = p;
        @(negedge clk);
        enabled = 1'b1;
        @(posedge clk);
        #1;
        enabled = 1'b0;
        e.t    = cyc;
        e.pc_n = p;
        q.push_back(e);
        if (poke) begin
            // A second request while busy must be ignored.
            @(negedge clk);
            pc = 32'h0000_0ABC;
            enabled = 1'b1;
            @(posedge clk);
            #1;
            enabled = 1'b0;
            pc = p;
        end
        for (int k = 0; k < 20 && !completed; k++) @(negedge clk);
        if (!completed) chk("timeout_completed", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_completed", {31'd0, completed}, 32'd0);
        chk("reset_rom_addr", rom_addr, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        issue(32'h0, 32'h00500093, mk(5'd1, 1, 0, 0, 3'd0, 32'd0, 32'd5, 0, 32'd0, 0, 5'd0), 0);
        regs[1] = 32'd7; regs[2] = 32'd7;
        issue(32'h100, 32'h00000463, mk(5'd0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 1, 32'h108, 0, 5'd0), 0);
        regs[2] = 32'h1001;
        issue(32'h20, 32'h008100E7, mk(5'd1, 1, 0, 0, 3'd0, 32'd0, 32'h24, 1, 32'h1008, 0, 5'd2), 0);
        regs[1] = 32'h8000_0000; regs[2] = 32'h24;
        issue(32'h40, 32'h4020D1B3, mk(5'd3, 1, 0, 0, 3'd5, 32'h24, 32'hF800_0000, 0, 32'd0, 0, 5'd1), 1);
        regs[1] = 32'd6; regs[2] = 32'd7;
`ifdef FDE_RV32M_EN
        issue(32'h60, 32'h022081B3, mk(5'd3, 1, 0, 0, 3'd0, 32'd7, 32'd42, 0, 32'd0, 0, 5'd1), 0);
`else
        issue(32'h60, 32'h022081B3, mk(5'd0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 0, 32'd0, 1, 5'd0), 0);
`endif
        regs[1] = 32'h1000; regs[2] = 32'hCAFE_BABE;
        issue(32'h80, 32'h0020A623, mk(5'd0, 0, 0, 1, 3'd2, 32'hCAFE_BABE, 32'h100C, 0, 32'd0, 0, 5'd1), 0);
        issue(32'hA0, 32'hFFC0A283, mk(5'd5, 1, 1, 0, 3'd2, 32'd0, 32'hFFC, 0, 32'd0, 0, 5'd1), 0);
        regs[1] = 32'hFFFF_FFFF; regs[2] = 32'd1;
        issue(32'h200, 32'hFE20CCE3, mk(5'd0, 0, 0, 0, 3'd4, 32'd1, 32'd0, 1, 32'h1F8, 0, 5'd1), 0);
        issue(32'h220, 32'hFE20ECE3, mk(5'd0, 0, 0, 0, 3'd6, 32'd1, 32'd0, 0, 32'h218, 0, 5'd1), 0);
        issue(32'h240, 32'hABCDE3B7, mk(5'd7, 1, 0, 0, 3'd0, 32'd0, 32'hABCD_E000, 0, 32'd0, 0, 5'd0), 0);
        issue(32'h300, 32'h00001397, mk(5'd7, 1, 0, 0, 3'd0, 32'd0, 32'h1300, 0, 32'd0, 0, 5'd0), 0);
        issue(32'h400, 32'h010000EF, mk(5'd1, 1, 0, 0, 3'd0, 32'd0, 32'h404, 1, 32'h410, 0, 5'd0), 0);
        regs[1] = 32'hFFFF_FFFE;
        issue(32'h420, 32'hFFF0A213, mk(5'd4, 1, 0, 0, 3'd2, 32'd0, 32'd1, 0, 32'd0, 0, 5'd1), 0);
        regs[1] = 32'hFFFF_FFFF; regs[2] = 32'd1;
        issue(32'h440, 32'h0020B233, mk(5'd4, 1, 0, 0, 3'd3, 32'd1, 32'd0, 0, 32'd0, 0, 5'd1), 0);
        regs[1] = 32'd5; regs[2] = 32'd7;
        issue(32'h460, 32'h402081B3, mk(5'd3, 1, 0, 0, 3'd0, 32'd7, 32'hFFFF_FFFE, 0, 32'd0, 0, 5'd1), 0);
        issue(32'h480, 32'h0000000F, mk(5'd0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 0, 32'd0, 0, 5'd0), 0);
        issue(32'h4A0, 32'hFFFFFFFF, mk(5'd0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 0, 32'd0, 1, 5'd0), 0);

        // Abort the next instruction with an asynchronous reset during FETCH2.
        rom_pc = 32'h500; rom_word = 32'h00500093; pc = 32'h500;
        @(negedge clk);
        enabled = 1'b1;
        @(posedge clk);
        #1;
        enabled = 1'b0;
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("abort_completed", {31'd0, completed}, 32'd0);
        chk("abort_rom_addr", rom_addr, 32'd0);
        chk("abort_illegal", {31'd0, illegal}, 32'd0);
        chk("abort_pc_n", pc_n, 32'd0);
        chk("abort_rs_a", {22'd0, rs1_a, rs2_a}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        chk("idle_after_abort", {31'd0, completed}, 32'd0);

        issue(32'h600, 32'h00500093, mk(5'd1, 1, 0, 0, 3'd0, 32'd0, 32'd5, 0, 32'd0, 0, 5'd0), 0);
        chk("queue_drained", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fde_unit.md
# fde_unit

Multi-cycle RV32I fetch/decode/execute front end for the core's stage pipeline. Each start request fetches one instruction from the instruction ROM, decodes it, reads its source operands from the external register file, and executes it. It then presents the ALU result, the branch decision and the decoded control fields to the memory/write-back stages through an `enabled`/`completed` handshake.

## Interface
Parameters: none.
- `clk`  in  1  clock, all state rising-edge
- `rstn`  in  1  asynchronous active-low reset
- `enabled`  in  1  start request, sampled only in IDLE or DONE
- `pc`  in  32  address of instruction to run
- `rom_addr`  out  32  instruction ROM address (registered pc)
- `rom_data`  in  32  ROM read data, valid 2 cycles after `rom_addr` changes
- `rs1_a`, `rs2_a`  out  5  register-file read addresses
- `rs1_v`, `rs2_v`  in  32  register-file read data, valid 1 cycle after addresses
- `completed`  out  1  results valid
- `pc_n`  out  32  pc of executed instruction
- `rd`  out  5  destination register
- `writes_to_reg`  out  1  rd write required (forced 0 when rd==0)
- `is_load`, `is_store`  out  1  memory op class
- `funct3`  out  3  width/sign for memory stage
- `store_data`  out  32  rs2 value
- `result`  out  32  ALU result or effective address
- `is_jump_chosen`  out  1  control transfer taken
- `jump_dest`  out  32  target pc
- `illegal`  out  1  unsupported encoding

## Operation
- FSM: IDLE→FETCH1→FETCH2→READ→EXEC→DONE.
  - `enabled` in IDLE/DONE latches `pc` and goes to FETCH1.
  - `enabled` in any other state is ignored.
- FETCH2 latches `rom_data` as the instruction.
- READ drives `rs1_a`/`rs2_a` from the instruction fields. Fields are zeroed for formats that do not read registers.
- EXEC registers all outputs, then enters DONE.
- Execution:
  - LUI: result = imm.
  - AUIPC: result = pc+imm.
  - JAL/JALR: result = pc+4, jump taken. dest = pc+imm, or (rs1+imm)&~1 for JALR.
  - Branches (BEQ/BNE/BLT/BGE/BLTU/BGEU): dest = pc+imm, taken per comparison.
  - Loads/stores: result = rs1+imm.
  - OP-IMM/OP: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
- Arithmetic is 32-bit wraparound. Shift amount is the low 5 bits. SRA/SRAI are arithmetic. SLT is signed, SLTU unsigned.
- Immediates are sign-extended per format (I/S/B/U/J).
- Illegal opcode or funct: `illegal`=1, `writes_to_reg`=0, `is_jump_chosen`=0, `is_load`/`is_store`=0, result 0.
- FENCE executes as a nop (legal).

## Timing
- `enabled` sampled at edge T → `completed`=1 from cycle T+4.
- `completed` stays high until the next accepted `enabled`, which clears it on that edge.
- Outputs hold their value throughout DONE.
- Reset (asynchronous, any state): FSM=IDLE, `completed`=0, every output 0, including `rom_addr`, `rs1_a`/`rs2_a` and `illegal`.
- Reset mid-operation aborts the instruction. No partial results are visible.

## Configuration
- `FDE_RV32M_EN` defined: MUL/MULH/MULHSU/MULHU (funct7=0000001, funct3 0–3) are decoded and executed in the EXEC cycle with correct signedness. DIV/REM encodings report `illegal`.
- `FDE_RV32M_EN` undefined: every funct7=0000001 OP encoding reports `illegal`.

## Structure
- Shared package `fde_pkg`:
  - opcode constants
  - funct3/funct7 constants
  - FSM state enum
  - `instructions` struct: decoded fields and flags
  - `regvpair` struct: rs1/rs2 values
- One sub-module, `fde_alu`: combinational ALU and branch comparator.
- Top level holds the FSM, fetch and decode logic.

## Test plan
- ADDI x1,x0,5 (0x00500093) at pc 0, enabled at T → `completed` at T+4; rd=1, `writes_to_reg`=1, result=5, `is_jump_chosen`=0.
- BEQ x0,x0,8 (0x00000463), pc 0x100, rs1_v=rs2_v=7 → `is_jump_chosen`=1, `jump_dest`=0x108, `writes_to_reg`=0.
- JALR x1,8(x2) (0x008100E7), pc 0x20, rs1_v=0x1001 → result 0x24, `jump_dest`=0x1008, `rs1_a`=2.
- SRA x3,x1,x2 (0x4020D1B3), rs1_v=0x80000000, rs2_v=0x24 → result 0xF8000000.
- 0xFFFFFFFF → `illegal`=1, `writes_to_reg`=0. Then `rstn` low during FETCH2 of the next instruction → `completed`=0 immediately, and returns to IDLE.
- MUL x3,x1,x2 (0x022081B3), rs1_v=6, rs2_v=7 → result 42 with `FDE_RV32M_EN` defined; `illegal`=1 without it.
